// File: rtl/wfg_drive_pat_pkg.sv
// Shared address map, register field positions and commit-state encoding
// for the drive-pattern Wishbone register bank.
package wfg_drive_pat_pkg;

  localparam logic [11:0] ADR_CTRL    = 12'h000;
  localparam logic [11:0] ADR_CFG     = 12'h004;
  localparam logic [11:0] ADR_STATUS  = 12'h008;
  localparam logic [11:0] ADR_PATSEL0 = 12'h100;
  localparam logic [11:0] ADR_PATSEL1 = 12'h200;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_COMMIT_BIT    = 1;
  localparam int CFG_BEGIN_LSB      = 0;
  localparam int CFG_END_LSB        = 8;
  localparam int CFG_CORE_SEL_BIT   = 16;
  localparam int CFG_WIDTH          = 17;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_ERRCNT_LSB  = 8;

  typedef enum logic {
    CS_IDLE    = 1'b0,
    CS_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/wfg_drive_pat_shadow_reg.sv
// Byte-enabled shadow word with an active copy that loads the shadow value
// present at the clock edge where commit_i is high.
module wfg_drive_pat_shadow_reg #(
  parameter int WIDTH = 32,
  localparam int SELW = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [SELW-1:0]  sel_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             commit_i,
  output logic [WIDTH-1:0] shadow_o,
  output logic [WIDTH-1:0] active_o
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    if (we_i) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (sel_i[b/8]) shadow_d[b] = wdata_i[b];
      end
    end
    // The active copy takes the pre-edge shadow, never a same-edge write.
    active_d = commit_i ? shadow_q : active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/wfg_drive_pat_wb_regbank.sv
// Double-buffered Wishbone register bank for the drive-pattern core; shadow
// registers are copied to the active outputs on COMMIT, deferred to sync_i while enabled.
module wfg_drive_pat_wb_regbank
  import wfg_drive_pat_pkg::*;
#(
  parameter int BUSW     = 32,
  parameter int CHANNELS = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [BUSW/8-1:0]   wbs_sel_i,
  input  logic [BUSW-1:0]     wbs_dat_i,
  input  logic [BUSW-1:0]     wbs_adr_i,
  output logic                wbs_ack_o,
  output logic                wbs_err_o,
  output logic [BUSW-1:0]     wbs_dat_o,
  input  logic                sync_i,
  output logic                en_q_o,
  output logic [7:0]          cfg_begin_q_o,
  output logic [7:0]          cfg_end_q_o,
  output logic                cfg_core_sel_q_o,
  output logic [CHANNELS-1:0] patsel0_q_o,
  output logic [CHANNELS-1:0] patsel1_q_o,
  output logic                commit_o
);

  localparam int NW      = CHANNELS / BUSW;
  localparam int CFG_SEL = (CFG_WIDTH + 7) / 8;

  // Bus handshake: a request is stb & cyc sampled while no termination is
  // outstanding; ack/err follows one cycle later for exactly one cycle.
  logic            ack_q, ack_d, err_q, err_d;
  logic            commit_q, commit_d;
  logic            en_q, en_d;
  logic [BUSW-1:0] dat_q, dat_d;
  logic [7:0]      errcnt_q, errcnt_d;
  commit_state_e   state_q, state_d;

  logic [9:0]      idx;
  logic [5:0]      widx;
  logic            req, wr, en_wr, commit_wr, do_copy;
  logic            hit_ctrl, hit_cfg, hit_status, hit_p0, hit_p1, mapped;
  logic            cfg_we;
  logic [NW-1:0]   p0_we, p1_we;
  logic [BUSW-1:0] rdata;

  logic [CFG_WIDTH-1:0] cfg_shadow, cfg_active;
  logic [BUSW-1:0]      p0_shadow [NW];
  logic [BUSW-1:0]      p1_shadow [NW];

  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[BUSW-1:12], wbs_adr_i[1:0]};

  assign idx        = wbs_adr_i[11:2];
  assign widx       = idx[5:0];
  assign hit_ctrl   = (idx == ADR_CTRL[11:2]);
  assign hit_cfg    = (idx == ADR_CFG[11:2]);
  assign hit_status = (idx == ADR_STATUS[11:2]);
  assign hit_p0     = (idx[9:6] == ADR_PATSEL0[11:8]) && (int'(widx) < NW);
  assign hit_p1     = (idx[9:6] == ADR_PATSEL1[11:8]) && (int'(widx) < NW);
  assign mapped     = hit_ctrl | hit_cfg | hit_status | hit_p0 | hit_p1;

  assign req = wbs_stb_i & wbs_cyc_i & ~(ack_q | err_q);
  assign wr  = req & wbs_we_i & mapped;

  always_comb begin
    rdata  = '0;
    cfg_we = wr & hit_cfg;
    p0_we  = '0;
    p1_we  = '0;
    if (hit_ctrl)   rdata[CTRL_EN_BIT] = en_q;
    if (hit_cfg)    rdata[CFG_WIDTH-1:0] = cfg_shadow;
    if (hit_status) begin
      rdata[STATUS_PENDING_BIT] = (state_q == CS_PENDING);
      rdata[STATUS_ERRCNT_LSB +: 8] = errcnt_q;
    end
    for (int i = 0; i < NW; i++) begin
      if (widx == 6'(i)) begin
        if (hit_p0) rdata = p0_shadow[i];
        if (hit_p1) rdata = p1_shadow[i];
        p0_we[i] = wr & hit_p0;
        p1_we[i] = wr & hit_p1;
      end
    end
  end

  always_comb begin
    ack_d     = req & mapped;
    err_d     = req & ~mapped;
    dat_d     = (req & ~wbs_we_i & mapped) ? rdata : '0;
    en_wr     = wr & hit_ctrl & wbs_sel_i[0];
    en_d      = en_wr ? wbs_dat_i[CTRL_EN_BIT] : en_q;
    commit_wr = en_wr & wbs_dat_i[CTRL_COMMIT_BIT];

    errcnt_d = errcnt_q;
    if (wr & hit_status)             errcnt_d = '0;
    else if (err_d && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;

    // EN as it stands after this write decides between immediate and deferred copy.
    state_d = state_q;
    do_copy = 1'b0;
    unique case (state_q)
      CS_IDLE: begin
        if (commit_wr) begin
          if (en_d) state_d = CS_PENDING;
          else      do_copy = 1'b1;
        end
      end
      CS_PENDING: begin
        if (sync_i || (en_wr && !wbs_dat_i[CTRL_EN_BIT])) begin
          do_copy = 1'b1;
          state_d = CS_IDLE;
        end
      end
      default: state_d = CS_IDLE;
    endcase
    commit_d = do_copy;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      commit_q <= 1'b0;
      en_q     <= 1'b0;
      errcnt_q <= '0;
      state_q  <= CS_IDLE;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      commit_q <= commit_d;
      en_q     <= en_d;
      errcnt_q <= errcnt_d;
      state_q  <= state_d;
    end
  end

  wfg_drive_pat_shadow_reg #(.WIDTH(CFG_WIDTH)) u_cfg (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .we_i     (cfg_we),
    .sel_i    (wbs_sel_i[CFG_SEL-1:0]),
    .wdata_i  (wbs_dat_i[CFG_WIDTH-1:0]),
    .commit_i (do_copy),
    .shadow_o (cfg_shadow),
    .active_o (cfg_active)
  );

  for (genvar g = 0; g < NW; g++) begin : g_word
    wfg_drive_pat_shadow_reg #(.WIDTH(BUSW)) u_p0 (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n_i),
      .we_i     (p0_we[g]),
      .sel_i    (wbs_sel_i),
      .wdata_i  (wbs_dat_i),
      .commit_i (do_copy),
      .shadow_o (p0_shadow[g]),
      .active_o (patsel0_q_o[BUSW*g +: BUSW])
    );
    wfg_drive_pat_shadow_reg #(.WIDTH(BUSW)) u_p1 (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n_i),
      .we_i     (p1_we[g]),
      .sel_i    (wbs_sel_i),
      .wdata_i  (wbs_dat_i),
      .commit_i (do_copy),
      .shadow_o (p1_shadow[g]),
      .active_o (patsel1_q_o[BUSW*g +: BUSW])
    );
  end

  assign wbs_ack_o        = ack_q;
  assign wbs_err_o        = err_q;
  assign wbs_dat_o        = dat_q;
  assign commit_o         = commit_q;
  assign en_q_o           = en_q;
  assign cfg_begin_q_o    = cfg_active[CFG_BEGIN_LSB +: 8];
  assign cfg_end_q_o      = cfg_active[CFG_END_LSB +: 8];
  assign cfg_core_sel_q_o = cfg_active[CFG_CORE_SEL_BIT];

endmodule

// File: doc/wfg_drive_pat_wb_regbank.md
# wfg_drive_pat_wb_regbank

Parametrised, double-buffered Wishbone register bank for the drive-pattern block. It generalises the fixed two-word pattern-select interface to `CHANNELS` output channels. It adds byte-lane writes, an error response for unmapped addresses, and shadow-to-active commit synchronised to the pattern generator's `sync_i` boundary. It sits between the Wishbone interconnect and `wfg_drive_pat` core logic, replacing the single-buffered register interface.

## Interface
- `BUSW`, 32: Wishbone data/address width; 32 only (`BUSW/8` byte lanes).
- `CHANNELS`, 64: pattern channels; a multiple of `BUSW`, 32..2048. `NW = CHANNELS/BUSW`.
- Clocking: one clock; reset is asynchronous and active-low.
- `wb_clk_i`  in  1  clock
- `wb_rst_n_i`  in  1  asynchronous active-low reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone strobe/cycle/write
- `wbs_sel_i`  in  `BUSW/8`  byte-lane enables
- `wbs_dat_i`  in  `BUSW`  write data
- `wbs_adr_i`  in  `BUSW`  byte address
- `wbs_ack_o`  out  1  normal termination
- `wbs_err_o`  out  1  error termination (unmapped address)
- `wbs_dat_o`  out  `BUSW`  read data
- `sync_i`  in  1  pattern-period boundary strobe from the core
- `en_q_o`  out  1  `CTRL.EN` (unshadowed)
- `cfg_begin_q_o`  out  8  active `CFG.BEGIN`
- `cfg_end_q_o`  out  8  active `CFG.END`
- `cfg_core_sel_q_o`  out  1  active `CFG.CORE_SEL`
- `patsel0_q_o`, `patsel1_q_o`  out  `CHANNELS`  active pattern-select planes
- `commit_o`  out  1  one-cycle pulse when active registers were just updated

## Operation
Address map uses `adr[11:2]`. `adr[1:0]` and `adr[BUSW-1:12]` are ignored.
- 0x000 CTRL: `EN[0]` (rw); `COMMIT[1]` (write-1 pulse, reads 0).
- 0x004 CFG (shadowed): `BEGIN[7:0]`, `END[15:8]`, `CORE_SEL[16]`.
- 0x008 STATUS (ro): `PENDING[0]`; `ERRCNT[15:8]`, saturating at 255, cleared by any write to STATUS.
- 0x100+4i, i<NW: `PATSEL0` word i (shadowed); bits map to channels `[BUSW*i +: BUSW]`.
- 0x200+4i, i<NW: `PATSEL1` word i (shadowed).
- Any other address is unmapped.

Access rules:
- **Writes:** update the byte lanes selected by `wbs_sel_i` only. Unselected bytes hold. `COMMIT` and `EN` are in byte 0.
- **Reads:** return shadow values. Unimplemented bits read 0. Unmapped reads return 0.
- **Unmapped access:** `wbs_err_o` instead of `wbs_ack_o`; no register changes; `ERRCNT` increments.

Commit (states IDLE / PENDING):
- IDLE, `COMMIT` written, `EN=0`: copy shadow to active on the same edge and pulse `commit_o`; stay IDLE.
- IDLE, `COMMIT` written, `EN=1`: go to PENDING.
- PENDING, `sync_i=1`: copy shadow to active, pulse `commit_o`, go to IDLE.
- PENDING, `EN` written 0: commit immediately, go to IDLE.
- `COMMIT` write coinciding with `sync_i`: enter PENDING; the coincident `sync_i` is not used.
- Shadow writes while PENDING are allowed; the values present at the copy edge are committed.
- Further `COMMIT` writes while PENDING have no extra effect.

## Timing
- Reset: all shadow, active and status registers 0; `wbs_ack_o`, `wbs_err_o`, `commit_o` 0; `wbs_dat_o` 0; state IDLE.
- Reset mid-transaction or while PENDING aborts it. No ack/err is issued; a pending commit is discarded.
- Termination: `ack`/`err` is registered and asserted exactly one cycle after `stb & cyc`. It lasts one cycle and is suppressed in the cycle it is high, so a held strobe yields one termination every 2 cycles.
- Write data lands in shadow on the edge that raises `ack`. Read data is valid while `ack` is high.
- `commit_o` is high in the cycle after the copy edge, coincident with the new active values.
- `en_q_o` changes on the write's ack edge.

## Structure
- Package `wfg_drive_pat_pkg`: address offsets, CTRL/CFG/STATUS field positions, commit-state enum.
- One sub-module `wfg_drive_pat_shadow_reg` (parameter `WIDTH`). It holds a byte-enabled shadow word plus the active copy and a commit input, and is instantiated per CFG/PATSEL word via generate.

## Test plan
- Reset, then read every mapped address -> all reads 0, ack exactly 1 cycle after strobe, `err=0`.
- `EN=0`: write `PATSEL0[1]=0xA5A5_0F0F` with `sel=4'b0101`, then `COMMIT` -> shadow reads `0x00A5_000F`; `patsel0_q_o[63:32]=0x00A5_000F`; `commit_o` pulses once.
- `EN=1`: write CFG `0x0001_2010`, then `COMMIT` -> STATUS reads 1; outputs unchanged until `sync_i` pulse; then `begin=0x10`, `end=0x20`, `core_sel=1`, STATUS reads 0.
- `COMMIT` and `sync_i` in the same cycle, then a second `sync_i` 5 cycles later -> copy only at the second `sync_i`.
- Access 0x300 three times -> `err` each time, no ack; STATUS reads `0x0000_0300`. Write STATUS -> `ERRCNT=0`.
- Assert reset while PENDING -> outputs 0, STATUS 0, no `commit_o` on a subsequent `sync_i`.
